// File: rtl/bcd_digit_reader.sv
// Snapshots eleven BCD decade digits on start and streams the significant ones MSB-first over valid/ready.
// First digit is visible one cycle after start; outputs hold while digit_ready is low; done pulses after the final digit is taken.
module bcd_digit_reader #(
  parameter int MAX_EXP     = 9,
  parameter bit BLANK_ZEROS = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ET0,
  input  logic [3:0] ET1,
  input  logic [3:0] ET2,
  input  logic [3:0] ET3,
  input  logic [3:0] ET4,
  input  logic [3:0] ET5,
  input  logic [3:0] ET6,
  input  logic [3:0] ET7,
  input  logic [3:0] ET8,
  input  logic [3:0] ET9,
  input  logic [3:0] ET10,
  input  logic [3:0] cur_exp,
  input  logic       start,
  input  logic       digit_ready,
  output logic [3:0] digit,
  output logic [3:0] digit_idx,
  output logic       digit_valid,
  output logic       last,
  output logic       bad_digit,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] MAX_E = 4'(MAX_EXP);

  state_t     state_q, state_d;
  logic [3:0] et_in  [0:10];
  logic [3:0] snap_q [0:10];
  logic [3:0] snap_d [0:10];
  logic [3:0] digit_q, digit_d;
  logic [3:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       bad_q, bad_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] e_clamp;
  logic [3:0] base_idx;
  logic [3:0] load_idx;
  logic       present;

  assign et_in[0]  = ET0;
  assign et_in[1]  = ET1;
  assign et_in[2]  = ET2;
  assign et_in[3]  = ET3;
  assign et_in[4]  = ET4;
  assign et_in[5]  = ET5;
  assign et_in[6]  = ET6;
  assign et_in[7]  = ET7;
  assign et_in[8]  = ET8;
  assign et_in[9]  = ET9;
  assign et_in[10] = ET10;

  // Start index: one above the clamped exponent, or the highest non-zero digit when blanking.
  always_comb begin
    e_clamp  = (cur_exp > MAX_E) ? MAX_E : cur_exp;
    base_idx = e_clamp + 4'd1;
    load_idx = base_idx;
    if (BLANK_ZEROS) begin
      load_idx = 4'd0;
      for (int i = 0; i < 11; i++) begin
        if ((4'(i) <= base_idx) && (et_in[i] != 4'd0)) load_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    digit_d = digit_q;
    valid_d = valid_q;
    last_d  = last_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    present = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = et_in;
          idx_d   = load_idx;
          state_d = SEND;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          present = 1'b1;
        end
      end
      SEND: begin
        if (digit_ready) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q - 4'd1;
            present = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (present) begin
      digit_d = snap_d[idx_d];
      last_d  = (idx_d == 4'd0);
      bad_d   = (snap_d[idx_d] > 4'h9);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= '{default: 4'd0};
      idx_q   <= 4'd0;
      digit_q <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign digit       = digit_q;
  assign digit_idx   = idx_q;
  assign digit_valid = valid_q;
  assign last        = last_q;
  assign bad_digit   = bad_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_bcd_digit_reader.sv
// Directed bench: instance 0 runs with BLANK_ZEROS=0, instance 1 with BLANK_ZEROS=1, sharing all inputs.
module tb_bcd_digit_reader;

  logic       clk;
  logic       rst;
  logic [3:0] et [0:10];
  logic [3:0] cur_exp;
  logic       start;
  logic       digit_ready;

  logic [3:0] dg   [2];
  logic [3:0] di   [2];
  logic       vl   [2];
  logic       ls   [2];
  logic       bd   [2];
  logic       bs   [2];
  logic       dn   [2];

  int passed = 0;
  int total  = 0;
  int xfers;

  bcd_digit_reader #(.MAX_EXP(9), .BLANK_ZEROS(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .ET0(et[0]), .ET1(et[1]), .ET2(et[2]), .ET3(et[3]), .ET4(et[4]), .ET5(et[5]),
    .ET6(et[6]), .ET7(et[7]), .ET8(et[8]), .ET9(et[9]), .ET10(et[10]),
    .cur_exp(cur_exp), .start(start), .digit_ready(digit_ready),
    .digit(dg[0]), .digit_idx(di[0]), .digit_valid(vl[0]), .last(ls[0]),
    .bad_digit(bd[0]), .busy(bs[0]), .done(dn[0])
  );

  bcd_digit_reader #(.MAX_EXP(9), .BLANK_ZEROS(1'b1)) u_dut_bz (
    .clk(clk), .rst(rst),
    .ET0(et[0]), .ET1(et[1]), .ET2(et[2]), .ET3(et[3]), .ET4(et[4]), .ET5(et[5]),
    .ET6(et[6]), .ET7(et[7]), .ET8(et[8]), .ET9(et[9]), .ET10(et[10]),
    .cur_exp(cur_exp), .start(start), .digit_ready(digit_ready),
    .digit(dg[1]), .digit_idx(di[1]), .digit_valid(vl[1]), .last(ls[1]),
    .bad_digit(bd[1]), .busy(bs[1]), .done(dn[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_digit(input int u, input string tag, input logic [3:0] d,
                           input logic [3:0] i, input logic l, input logic b);
    chk({tag, ".valid"}, 8'(vl[u]), 8'd1);
    chk({tag, ".busy"},  8'(bs[u]), 8'd1);
    chk({tag, ".digit"}, 8'(dg[u]), 8'(d));
    chk({tag, ".idx"},   8'(di[u]), 8'(i));
    chk({tag, ".last"},  8'(ls[u]), 8'(l));
    chk({tag, ".bad"},   8'(bd[u]), 8'(b));
  endtask

  task automatic chk_idle(input int u, input string tag, input logic exp_done);
    chk({tag, ".valid"}, 8'(vl[u]), 8'd0);
    chk({tag, ".busy"},  8'(bs[u]), 8'd0);
    chk({tag, ".last"},  8'(ls[u]), 8'd0);
    chk({tag, ".done"},  8'(dn[u]), 8'(exp_done));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [3:0] v);
    for (int k = 0; k < 11; k++) et[k] = v;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    digit_ready = 1'b0;
    cur_exp = 4'd0;
    set_all(4'd0);
    step();
    chk_idle(0, "reset0", 1'b0);
    chk_idle(1, "reset1", 1'b0);
    chk("reset.digit", 8'(dg[0]), 8'd0);
    chk("reset.idx", 8'(di[0]), 8'd0);
    chk("reset.bad", 8'(bd[0]), 8'd0);
    rst = 1'b0;
    step();

    // 1: two digits back-to-back
    et[1] = 4'd4; et[0] = 4'd7; cur_exp = 4'd0; digit_ready = 1'b1;
    start = 1'b1;
    step(); start = 1'b0;
    chk("t1.done_early", 8'(dn[0]), 8'd0);
    chk_digit(0, "t1.d0", 4'd4, 4'd1, 1'b0, 1'b0);
    step();
    chk_digit(0, "t1.d1", 4'd7, 4'd0, 1'b1, 1'b0);
    step();
    chk_idle(0, "t1.end", 1'b1);
    step();
    chk_idle(0, "t1.after", 1'b0);

    // 2: stalls with ready pattern 0,0,1,0,1,1,1
    set_all(4'd0);
    et[3] = 4'd1; et[2] = 4'd0; et[1] = 4'd5; et[0] = 4'd3; cur_exp = 4'd2;
    digit_ready = 1'b0; start = 1'b1;
    xfers = 0;
    begin
      logic       rdy [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [3:0] ed  [7] = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd5, 4'd3};
      logic [3:0] ei  [7] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
      for (int c = 0; c < 7; c++) begin
        step(); start = 1'b0;
        chk_digit(0, $sformatf("t2.c%0d", c), ed[c], ei[c], (ei[c] == 4'd0), 1'b0);
        chk($sformatf("t2.c%0d.done", c), 8'(dn[0]), 8'd0);
        digit_ready = rdy[c];
        if (rdy[c] && vl[0]) xfers++;
      end
    end
    step();
    chk_idle(0, "t2.end", 1'b1);
    chk("t2.xfers", 8'(xfers), 8'd4);

    // 3: inputs change and start repeats mid-transfer
    set_all(4'd0);
    et[2] = 4'd2; et[1] = 4'd6; et[0] = 4'd8; cur_exp = 4'd1;
    digit_ready = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(0, "t3.d0", 4'd2, 4'd2, 1'b0, 1'b0);
    set_all(4'd9); cur_exp = 4'd5; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(0, "t3.d1", 4'd6, 4'd1, 1'b0, 1'b0);
    step();
    chk_digit(0, "t3.d2", 4'd8, 4'd0, 1'b1, 1'b0);
    step();
    chk_idle(0, "t3.end", 1'b1);
    step();
    chk_idle(0, "t3.after", 1'b0);

    // 4: leading-zero blanking
    set_all(4'd0);
    et[0] = 4'd5; cur_exp = 4'd0; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(1, "t4.bz.d0", 4'd5, 4'd0, 1'b1, 1'b0);
    chk_digit(0, "t4.nb.d0", 4'd0, 4'd1, 1'b0, 1'b0);
    step();
    chk_idle(1, "t4.bz.end", 1'b1);
    chk_digit(0, "t4.nb.d1", 4'd5, 4'd0, 1'b1, 1'b0);
    step();
    chk_idle(0, "t4.nb.end", 1'b1);
    chk_idle(1, "t4.bz.after", 1'b0);
    set_all(4'd0); cur_exp = 4'd3; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(1, "t4.z.d0", 4'd0, 4'd0, 1'b1, 1'b0);
    chk_digit(0, "t4.z.nb0", 4'd0, 4'd4, 1'b0, 1'b0);
    step();
    chk_idle(1, "t4.z.end", 1'b1);
    for (int c = 1; c < 5; c++) step();
    chk_idle(0, "t4.z.nbend", 1'b1);

    // 5: clamp of cur_exp and a bad top digit
    set_all(4'd1); et[10] = 4'hC; cur_exp = 4'hF; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(0, "t5.d10", 4'hC, 4'd10, 1'b0, 1'b1);
    xfers = 1;
    for (int c = 1; c < 11; c++) begin
      step();
      chk_digit(0, $sformatf("t5.c%0d", c), 4'd1, 4'(10 - c), (c == 10), 1'b0);
      if (vl[0]) xfers++;
    end
    step();
    chk_idle(0, "t5.end", 1'b1);
    chk("t5.xfers", 8'(xfers), 8'd11);

    // 6: asynchronous reset at idx 2
    set_all(4'd0);
    et[3] = 4'd4; et[2] = 4'd3; et[1] = 4'd2; et[0] = 4'd1; cur_exp = 4'd2; start = 1'b1;
    step(); start = 1'b0;
    chk_digit(0, "t6.d0", 4'd4, 4'd3, 1'b0, 1'b0);
    step();
    chk_digit(0, "t6.d1", 4'd3, 4'd2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_idle(0, "t6.rst", 1'b0);
    chk("t6.rst.idx", 8'(di[0]), 8'd0);
    step(); rst = 1'b0;
    step();
    chk_idle(0, "t6.nodone", 1'b0);
    start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      chk_digit(0, $sformatf("t6.r%0d", c), 4'(4 - c), 4'(3 - c), (c == 3), 1'b0);
    end
    step();
    chk_idle(0, "t6.end", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_digit_reader.md
Name: bcd_digit_reader

Overview:
- Reads the decade-counter outputs: eleven BCD digits ET0..ET10 plus cur_exp, the highest exponent reached.
- On a start pulse, snapshots all digits and cur_exp.
- Emits the significant digits one at a time over a valid/ready stream, most-significant first, to a display/UART formatter downstream.
- Sits between the running-average counter and the output formatting logic.

Parameters:
- MAX_EXP, 9, clamp ceiling for cur_exp; the first emitted index is min(cur_exp, MAX_EXP)+1, so the maximum index is 10.
- BLANK_ZEROS, 0, when 1, leading zero digits above index 0 are skipped at load.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- ET0..ET10  input  4 each  BCD digits from the counter, ET0 least significant
- cur_exp  input  4  exponent from the counter
- start  input  1  single-cycle request to snapshot and emit
- digit_ready  input  1  downstream accepts the current digit
- digit  output  4  current digit value
- digit_idx  output  4  decade index of the current digit, 0..10
- digit_valid  output  1  digit/digit_idx/last/bad_digit are valid
- last  output  1  current digit is index 0, the final digit
- bad_digit  output  1  current digit > 9; qualified by digit_valid
- busy  output  1  a transfer is in progress
- done  output  1  one-cycle pulse after the final digit is accepted

Behaviour:
- Reset (async, rst=1): state=IDLE and all outputs 0. This covers digit, digit_idx, digit_valid, last, bad_digit, busy and done. The snapshot registers are cleared to 0.
- Reset mid-transfer aborts immediately. No done pulse; the next start after rst deasserts behaves normally.
- FSM states: IDLE, SEND.
- IDLE:
  - digit_valid=0, busy=0.
  - If start=1 at a rising edge, capture ET0..ET10 into the snapshot and load idx.
  - Base idx: e = cur_exp clamped to MAX_EXP; idx = e+1.
  - If BLANK_ZEROS=1, idx = highest i <= e+1 with snapshot digit i != 0, or 0 if none. This uses a priority search over the captured input values in the same cycle.
  - Go to SEND.
- Latency: start sampled at edge N gives digit_valid=1 and busy=1 from edge N onward, visible in cycle N+1.
- SEND:
  - digit_valid=1, busy=1.
  - digit=snap[idx], digit_idx=idx, last=(idx==0), bad_digit=(snap[idx]>4'h9).
  - All are registered and held stable while digit_valid=1 and digit_ready=0.
  - Transfer occurs at an edge with digit_valid & digit_ready.
  - On transfer with idx>0: idx<=idx-1, stay in SEND. Back-to-back transfers at 1 digit/cycle when digit_ready is held high.
  - On transfer with idx==0: go to IDLE, digit_valid<=0, busy<=0, last<=0, done<=1 for exactly one cycle.
- start while busy=1 is ignored: no re-snapshot and no queuing.
- start in the same cycle done is high: state is IDLE, so it is accepted.
- Input changes after the snapshot do not affect emitted digits.
- Digit count per transfer: e+2 when BLANK_ZEROS=0; between 1 and e+2 when BLANK_ZEROS=1.
- Digits > 9 are passed through unmodified, with bad_digit flagged. There is no other error handling.
- digit_ready while digit_valid=0 has no effect.

Test Plan:
1. BLANK_ZEROS=0; cur_exp=0, ET1=4, ET0=7, digit_ready=1; pulse start -> (digit=4, idx=1, last=0), then (digit=7, idx=0, last=1) on consecutive cycles; done high for 1 cycle after; busy low afterwards.
2. cur_exp=2, ET3=1, ET2=0, ET1=5, ET0=3; digit_ready toggles 0,0,1,0,1,1,1 -> emits 1,0,5,3 with idx 3,2,1,0; outputs held stable during every stall; exactly 4 transfers.
3. Start, then change all ET inputs to 9 and pulse start again during SEND -> emitted digits match the original snapshot; second start ignored; single done.
4. BLANK_ZEROS=1; cur_exp=0, ET1=0, ET0=5 -> one digit (5, idx=0, last=1). Repeat with all digits 0 -> one digit (0, idx=0).
5. cur_exp=4'hF, ET10=4'hC, ET9..ET0=1 -> first digit idx=10, digit=4'hC, bad_digit=1; next 10 digits are 1 with bad_digit=0; 11 transfers total.
6. Assert rst asynchronously while idx=2 in SEND -> digit_valid, busy, done, last immediately 0; no done pulse. New start produces a full, correct sequence.
